python_frame_seq: RTL and testbench

Frame sequencer for the Python sensor simulation model. It generates the parallel-side `i_fval`, `i_lval` and `iv_pix_data` stimulus that feeds the map/format/ctrl-insert/serializer chain, on the parallel clock domain. Frame geometry comes from configuration inputs latched per frame, and the pixel pattern is selectable. It runs on trigger or free-run, and is gated by sensor register init completion.

---
 rtl/python_frame_seq.sv | 193 +++++++++++++++++++
 tb/tb_python_frame_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/python_frame_seq.sv
// Parallel-side frame sequencer for the Python sensor model: generates fval/lval/pixel
// groups from per-frame latched geometry, on trigger or free-run, gated by init_done.
module python_frame_seq #(
  parameter int DATA_WIDTH  = 10,
  parameter int CHANNEL_NUM = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_init_done,
  input  logic                              i_free_run,
  input  logic                              i_trigger,
  input  logic [CNT_WIDTH-1:0]              iv_line_width,
  input  logic [CNT_WIDTH-1:0]              iv_line_num,
  input  logic [CNT_WIDTH-1:0]              iv_fval_lead,
  input  logic [CNT_WIDTH-1:0]              iv_fval_trail,
  input  logic [CNT_WIDTH-1:0]              iv_hblank,
  input  logic [CNT_WIDTH-1:0]              iv_vblank,
  input  logic [1:0]                        iv_pattern_sel,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                              o_frame_start,
  output logic                              o_frame_end,
  output logic                              o_busy,
  output logic [CNT_WIDTH-1:0]              ov_frame_cnt,
  output logic [2:0]                        ov_dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    LINE   = 3'd2,
    HBLANK = 3'd3,
    TRAIL  = 3'd4,
    VBLANK = 3'd5
  } state_t;

  state_t                 state, next_state;
  logic [CNT_WIDTH-1:0]   cnt, next_cnt;
  logic [CNT_WIDTH-1:0]   line_idx, next_line;
  logic [CNT_WIDTH-1:0]   width_q, num_q, lead_q, trail_q, hblank_q, vblank_q;
  logic [1:0]             sel_q;
  logic                   load;

  logic                   geom_ok, start_idle, start_chain;
  logic [CNT_WIDTH-1:0]   hblank_dur, vblank_dur;

  logic                   nxt_fval, nxt_lval, nxt_start, nxt_end;
  logic [CNT_WIDTH-1:0]   nxt_frame_cnt;
  logic [1:0]             nxt_sel;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] nxt_pix;
  logic [CNT_WIDTH-1:0]   pix_base, pix_val;
  logic [DATA_WIDTH-1:0]  chan;

  assign geom_ok     = (iv_line_width != '0) && (iv_line_num != '0);
  // From IDLE a trigger or free-run starts a frame; chaining out of VBLANK needs free-run.
  assign start_idle  = i_init_done && (i_free_run || i_trigger) && geom_ok;
  assign start_chain = i_init_done && i_free_run && geom_ok;
  assign hblank_dur  = (hblank_q == '0) ? CNT_WIDTH'(1) : hblank_q;
  assign vblank_dur  = (vblank_q == '0) ? CNT_WIDTH'(1) : vblank_q;

  always_comb begin
    next_state = state;
    next_cnt   = cnt + CNT_WIDTH'(1);
    next_line  = line_idx;
    load       = 1'b0;
    case (state)
      IDLE: begin
        next_cnt = '0;
        if (start_idle) begin
          load       = 1'b1;
          next_line  = '0;
          next_state = (iv_fval_lead == '0) ? LINE : LEAD;
        end
      end
      LEAD: begin
        if (cnt == lead_q - CNT_WIDTH'(1)) begin
          next_state = LINE;
          next_cnt   = '0;
        end
      end
      LINE: begin
        if (cnt == width_q - CNT_WIDTH'(1)) begin
          next_cnt = '0;
          if (line_idx == num_q - CNT_WIDTH'(1))
            next_state = (trail_q == '0) ? VBLANK : TRAIL;
          else
            next_state = HBLANK;
        end
      end
      HBLANK: begin
        if (cnt == hblank_dur - CNT_WIDTH'(1)) begin
          next_state = LINE;
          next_cnt   = '0;
          next_line  = line_idx + CNT_WIDTH'(1);
        end
      end
      TRAIL: begin
        if (cnt == trail_q - CNT_WIDTH'(1)) begin
          next_state = VBLANK;
          next_cnt   = '0;
        end
      end
      VBLANK: begin
        if (cnt == vblank_dur - CNT_WIDTH'(1)) begin
          next_cnt = '0;
          if (start_chain) begin
            load       = 1'b1;
            next_line  = '0;
            next_state = (iv_fval_lead == '0) ? LINE : LEAD;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so every output is a flop.
  always_comb begin
    nxt_fval      = next_state inside {LEAD, LINE, HBLANK, TRAIL};
    nxt_lval      = (next_state == LINE);
    nxt_start     = load;
    nxt_end       = (next_state == VBLANK) && (state != VBLANK);
    nxt_frame_cnt = nxt_end ? ov_frame_cnt + CNT_WIDTH'(1) : ov_frame_cnt;
    nxt_sel       = load ? iv_pattern_sel : sel_q;
    nxt_pix       = '0;
    pix_base      = next_cnt * CNT_WIDTH'(CHANNEL_NUM);
    pix_val       = '0;
    chan          = '0;
    if (nxt_sel == 2'd1)
      pix_base = pix_base + next_line;
    for (int k = 0; k < CHANNEL_NUM; k++) begin
      pix_val = pix_base + CNT_WIDTH'(k);
      case (nxt_sel)
        2'd2:    chan = '1;
        2'd3:    chan = DATA_WIDTH'(nxt_frame_cnt);
        default: chan = DATA_WIDTH'(pix_val);
      endcase
      nxt_pix[k*DATA_WIDTH +: DATA_WIDTH] = nxt_lval ? chan : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      line_idx      <= '0;
      width_q       <= '0;
      num_q         <= '0;
      lead_q        <= '0;
      trail_q       <= '0;
      hblank_q      <= '0;
      vblank_q      <= '0;
      sel_q         <= '0;
      o_fval        <= 1'b0;
      o_lval        <= 1'b0;
      ov_pix_data   <= '0;
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;
      o_busy        <= 1'b0;
      ov_frame_cnt  <= '0;
    end else begin
      state         <= next_state;
      cnt           <= next_cnt;
      line_idx      <= next_line;
      o_fval        <= nxt_fval;
      o_lval        <= nxt_lval;
      ov_pix_data   <= nxt_pix;
      o_frame_start <= nxt_start;
      o_frame_end   <= nxt_end;
      o_busy        <= (next_state != IDLE);
      ov_frame_cnt  <= nxt_frame_cnt;
      if (load) begin
        width_q  <= iv_line_width;
        num_q    <= iv_line_num;
        lead_q   <= iv_fval_lead;
        trail_q  <= iv_fval_trail;
        hblank_q <= iv_hblank;
        vblank_q <= iv_vblank;
        sel_q    <= iv_pattern_sel;
      end
    end
  end

  assign ov_dbg_state = state;

endmodule

// File: tb/tb_python_frame_seq.sv
// Bench for python_frame_seq: a frame-level reference model expands each started frame
// into its expected per-cycle outputs; a negedge monitor compares the DUT against them.
module tb_python_frame_seq;
  localparam int DW = 10;
  localparam int CH = 4;
  localparam int CW = 16;
  localparam int PW = DW * CH;

  typedef struct packed {
    logic          fval;
    logic          lval;
    logic          fs;
    logic          fe;
    logic          busy;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pix;
  } ent_t;
  localparam int EW = $bits(ent_t);

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          init_done, free_run, trigger;
  logic [CW-1:0] line_width, line_num, fval_lead, fval_trail, hblank, vblank;
  logic [1:0]    pattern_sel;
  logic          fval, lval, frame_start, frame_end, busy;
  logic [PW-1:0] pix_data;
  logic [CW-1:0] frame_cnt;
  logic [2:0]    dbg_state;

  python_frame_seq #(.DATA_WIDTH(DW), .CHANNEL_NUM(CH), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_init_done   (init_done),
    .i_free_run    (free_run),
    .i_trigger     (trigger),
    .iv_line_width (line_width),
    .iv_line_num   (line_num),
    .iv_fval_lead  (fval_lead),
    .iv_fval_trail (fval_trail),
    .iv_hblank     (hblank),
    .iv_vblank     (vblank),
    .iv_pattern_sel(pattern_sel),
    .o_fval        (fval),
    .o_lval        (lval),
    .ov_pix_data   (pix_data),
    .o_frame_start (frame_start),
    .o_frame_end   (frame_end),
    .o_busy        (busy),
    .ov_frame_cnt  (frame_cnt),
    .ov_dbg_state  (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  ent_t          plan_q[$];
  logic [EW-1:0] exp_q[$];
  int            fcnt = 0;
  bit            last_vb = 0;
  bit            first_pending = 0;

  function automatic logic [PW-1:0] pix_of(input int sel, input int l, input int g, input int fc);
    logic [PW-1:0] px;
    int v;
    px = '0;
    for (int k = 0; k < CH; k++) begin
      case (sel)
        0: v = g * CH + k;
        1: v = l + g * CH + k;
        2: v = (1 << DW) - 1;
        default: v = fc;
      endcase
      px[k*DW +: DW] = DW'(v % (1 << DW));
    end
    return px;
  endfunction

  task automatic add(input logic fv, input logic lv, input int c, input logic [PW-1:0] px,
                     input bit fe);
    ent_t e;
    e.fval = fv; e.lval = lv; e.fs = first_pending; e.fe = fe; e.busy = 1'b1;
    e.cnt = CW'(c); e.pix = px;
    first_pending = 0;
    plan_q.push_back(e);
  endtask

  // Expand one whole frame (lead, lines, blanks, trail, vblank) from the start-time config.
  task automatic expand(input int w, input int n, input int ld, input int tr, input int h,
                        input int v, input int sel);
    int nc;
    nc = (fcnt + 1) % (1 << CW);
    first_pending = 1;
    for (int i = 0; i < ld; i++) add(1, 0, fcnt, '0, 0);
    for (int l = 0; l < n; l++) begin
      for (int g = 0; g < w; g++) add(1, 1, fcnt, pix_of(sel, l, g, fcnt), 0);
      if (l < n - 1)
        for (int i = 0; i < ((h == 0) ? 1 : h); i++) add(1, 0, fcnt, '0, 0);
    end
    for (int i = 0; i < tr; i++) add(1, 0, fcnt, '0, 0);
    for (int i = 0; i < ((v == 0) ? 1 : v); i++) add(0, 0, nc, '0, (i == 0));
    fcnt = nc;
  endtask

  always @(posedge clk) begin
    ent_t e;
    if (reset) begin
      plan_q.delete();
      fcnt = 0;
      last_vb = 0;
      e = '0;
      exp_q.push_back(e);
    end else begin
      if (plan_q.size() == 0) begin
        if (init_done && (free_run || (trigger && !last_vb)) && line_width != 0 && line_num != 0)
          expand(int'(line_width), int'(line_num), int'(fval_lead), int'(fval_trail),
                 int'(hblank), int'(vblank), int'(pattern_sel));
        else begin
          e = '0;
          e.cnt = CW'(fcnt);
          plan_q.push_back(e);
        end
      end
      e = plan_q.pop_front();
      last_vb = e.busy && !e.fval;
      exp_q.push_back(e);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int fval_run = 0;
  int last_fval_len = -1;

  always @(negedge clk) begin
    ent_t act;
    logic [EW-1:0] exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = '{fval, lval, frame_start, frame_end, busy, frame_cnt, pix_data};
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_outputs: got %0h expected %0h at %0t", act, exp, $time);
      end
    end
    if (fval) fval_run++;
    else if (fval_run != 0) begin
      last_fval_len = fval_run;
      fval_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_geom(input int w, input int n, input int ld, input int tr, input int h,
                          input int v, input int sel);
    line_width = CW'(w); line_num = CW'(n); fval_lead = CW'(ld); fval_trail = CW'(tr);
    hblank = CW'(h); vblank = CW'(v); pattern_sel = 2'(sel);
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
  endtask

  task automatic wait_lval(input string nm, output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (lval) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: lval never rose within 60 cycles", nm);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    init_done = 1'b1; free_run = 1'b0; trigger = 1'b0;
    set_geom(4, 3, 2, 1, 2, 3, 0);
    tick(3);
    check("reset_fval", 64'(fval), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    reset = 1'b0;
    tick(2);

    // triggered frame, basic geometry
    pulse_trigger();
    tick(30);
    check("basic_fval_len", 64'(last_fval_len), 64'd19);
    check("basic_frame_cnt", 64'(frame_cnt), 64'd1);

    // gating and refused starts
    init_done = 1'b0;
    pulse_trigger();
    tick(5);
    init_done = 1'b1;
    set_geom(4, 0, 2, 1, 2, 3, 0);
    pulse_trigger();
    tick(5);
    check("refused_busy", 64'(busy), 64'd0);
    set_geom(4, 3, 2, 1, 2, 3, 0);
    pulse_trigger();
    tick(5);
    pulse_trigger();
    tick(40);
    check("busy_trigger_no_queue", 64'(frame_cnt), 64'd2);

    // pattern 3 on the third frame
    set_geom(4, 3, 2, 1, 2, 3, 3);
    pulse_trigger();
    wait_lval("sel3_lval", ok);
    if (ok) check("sel3_data", 64'(pix_data), 64'({CH{10'd2}}));
    tick(30);

    // pattern 1 and pattern 2
    set_geom(4, 3, 0, 1, 1, 1, 1);
    pulse_trigger();
    tick(30);
    set_geom(3, 2, 1, 0, 0, 0, 2);
    pulse_trigger();
    wait_lval("sel2_lval", ok);
    if (ok) check("sel2_data", 64'(pix_data), 64'({CH{10'h3FF}}));
    tick(20);

    // free-run period, then config latching across a mid-frame width change
    set_geom(2, 2, 0, 0, 0, 0, 0);
    free_run = 1'b1;
    tick(30);
    check("free_run_fval_len", 64'(last_fval_len), 64'd5);
    set_geom(4, 2, 1, 1, 1, 1, 0);
    tick(10);
    line_width = CW'(8);
    tick(50);
    init_done = 1'b0;
    tick(40);
    check("init_drop_idle", 64'(busy), 64'd0);
    init_done = 1'b1;
    free_run = 1'b0;

    // reset mid-LINE
    set_geom(8, 2, 0, 0, 0, 0, 0);
    pulse_trigger();
    tick(3);
    reset = 1'b1;
    tick(1);
    check("midreset_fval", 64'(fval), 64'd0);
    check("midreset_frame_end", 64'(frame_end), 64'd0);
    check("midreset_frame_cnt", 64'(frame_cnt), 64'd0);
    check("midreset_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    tick(2);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      set_geom($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
               $urandom_range(0, 3));
      free_run  = ($urandom_range(0, 3) == 0);
      init_done = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1) pulse_trigger();
      tick($urandom_range(1, 30));
    end

    free_run = 1'b0;
    trigger = 1'b0;
    init_done = 1'b1;
    tick(120);
    check("drain_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
